// File: rtl/wb_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkt_pkg
//  Description : Shared types and header layout for the write-back result
//                packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        TRAILER = 2'd3
    } pkt_state_t;

    localparam logic [15:0] C_DEFAULT_HEADER_TAG = 16'hA5A5;

    // Header word layout: tag [31:16], seq [15:8], len [7:0]
    localparam int C_HDR_TAG_LSB = 16;
    localparam int C_HDR_SEQ_LSB = 8;
    localparam int C_HDR_LEN_LSB = 0;

    function automatic logic [31:0] make_header(input logic [15:0] tag,
                                                input logic [7:0]  seq,
                                                input logic [7:0]  len);
        logic [31:0] h;
        h = '0;
        h[C_HDR_TAG_LSB +: 16] = tag;
        h[C_HDR_SEQ_LSB +: 8]  = seq;
        h[C_HDR_LEN_LSB +: 8]  = len;
        return h;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Show-ahead synchronous FIFO; a push at full is accepted when
//                a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_wdata,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [WIDTH-1:0]             o_next,
    output logic                         o_accept,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int C_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_LW = $clog2(DEPTH+1);
    localparam logic [C_LW-1:0] C_FULL = C_LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wptr;
    logic [C_AW-1:0]  r_rptr;
    logic [C_LW-1:0]  r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_level != '0);
    assign w_do_push = i_push && ((r_level != C_FULL) || w_do_pop);

    assign o_accept = w_do_push;
    assign o_level  = r_level;
    assign o_head   = r_mem[r_rptr];
    // Entry behind the head lets the reader register the following word early.
    assign o_next   = r_mem[r_rptr + 1'b1];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_result_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_packetizer
//  Description : Captures write-back results into a FIFO and emits framed
//                header/payload/checksum packets on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_result_packetizer
    import wb_pkt_pkg::*;
#(
    parameter int          PAYLOAD_WORDS = 4,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] HEADER_TAG    = C_DEFAULT_HEADER_TAG
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [31:0]                       wb_data,
    input  logic                              wb_valid,
    output logic [31:0]                       pkt_data,
    output logic                              pkt_valid,
    input  logic                              pkt_ready,
    output logic                              pkt_last,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);

    localparam int              C_LW        = $clog2(FIFO_DEPTH+1);
    localparam logic [C_LW-1:0] C_PKT_LVL   = C_LW'(PAYLOAD_WORDS);
    localparam logic [7:0]      C_LEN       = 8'(PAYLOAD_WORDS);
    localparam logic [7:0]      C_LAST_BEAT = 8'(PAYLOAD_WORDS - 1);

    pkt_state_t       r_state;
    logic [7:0]       r_seq;
    logic [7:0]       r_beat;
    logic [31:0]      r_csum;
    logic             w_pop;
    logic             w_accept;
    logic [31:0]      w_head;
    logic [31:0]      w_next;
    logic [C_LW-1:0]  w_level_next;

    // pkt_valid is always high in PAYLOAD, so ready alone is the handshake.
    assign w_pop        = (r_state == PAYLOAD) && pkt_ready;
    assign w_level_next = fifo_level + C_LW'(w_accept) - C_LW'(w_pop);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (wb_valid),
        .i_wdata  (wb_data),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_next   (w_next),
        .o_accept (w_accept),
        .o_level  (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (wb_valid && !w_accept) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_seq     <= 8'h00;
            r_beat    <= 8'h00;
            r_csum    <= 32'h0;
            pkt_data  <= 32'h0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fifo_level >= C_PKT_LVL) begin
                        r_state   <= HEADER;
                        pkt_valid <= 1'b1;
                        pkt_last  <= 1'b0;
                        pkt_data  <= make_header(HEADER_TAG, r_seq, C_LEN);
                    end
                end
                HEADER: begin
                    if (pkt_ready) begin
                        r_state  <= PAYLOAD;
                        r_beat   <= 8'h00;
                        r_csum   <= 32'h0;
                        pkt_data <= w_head;
                    end
                end
                PAYLOAD: begin
                    if (pkt_ready) begin
                        r_csum <= r_csum ^ w_head;
                        r_beat <= r_beat + 8'h01;
                        if (r_beat == C_LAST_BEAT) begin
                            r_state  <= TRAILER;
                            pkt_data <= r_csum ^ w_head;
                            pkt_last <= 1'b1;
                        end else begin
                            pkt_data <= w_next;
                        end
                    end
                end
                TRAILER: begin
                    if (pkt_ready) begin
                        r_seq    <= r_seq + 8'h01;
                        pkt_last <= 1'b0;
                        if (w_level_next >= C_PKT_LVL) begin
                            r_state  <= HEADER;
                            pkt_data <= make_header(HEADER_TAG, r_seq + 8'h01, C_LEN);
                        end else begin
                            r_state   <= IDLE;
                            pkt_valid <= 1'b0;
                            pkt_data  <= 32'h0;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    pkt_valid <= 1'b0;
                    pkt_last  <= 1'b0;
                    pkt_data  <= 32'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_result_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_result_packetizer
//  Description : Scoreboard bench for the write-back result packetizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_result_packetizer;

    localparam int C_N     = 4;
    localparam int C_DEPTH = 8;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        reset;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_last;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int          n_checks;
    int          n_fails;
    int          hs_count;
    int          stall_seen;
    beat_t       exp_q[$];
    logic [7:0]  m_seq;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    wb_result_packetizer #(
        .PAYLOAD_WORDS (C_N),
        .FIFO_DEPTH    (C_DEPTH),
        .HEADER_TAG    (16'hA5A5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_last   (pkt_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes happen at posedge; inputs change at posedge+1, so the
    // negedge sees exactly the values the next posedge will use.
    always @(negedge clk) begin
        beat_t e;
        if (reset && pkt_valid && pkt_ready) begin
            n_checks++;
            hs_count++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL beat_unexpected: got data=%h last=%b, expected no beat", pkt_data, pkt_last);
            end else begin
                e = exp_q.pop_front();
                if (pkt_data !== e.data || pkt_last !== e.last) begin
                    n_fails++;
                    $display("FAIL beat: got data=%h last=%b, expected data=%h last=%b",
                             pkt_data, pkt_last, e.data, e.last);
                end
            end
        end
        if (reset && prev_stall) begin
            n_checks++;
            if (pkt_valid !== 1'b1 || pkt_data !== prev_data || pkt_last !== prev_last) begin
                n_fails++;
                $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                         pkt_valid, pkt_data, pkt_last, prev_data, prev_last);
            end
        end
        prev_stall = reset && pkt_valid && !pkt_ready;
        if (prev_stall) stall_seen++;
        prev_data  = pkt_data;
        prev_last  = pkt_last;
    end

    task automatic expect_packet(input logic [31:0] w [C_N]);
        beat_t       b;
        logic [31:0] cs;
        cs = 32'h0;
        b.data = {16'hA5A5, m_seq, 8'(C_N)};
        b.last = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < C_N; i++) begin
            b.data = w[i];
            b.last = 1'b0;
            exp_q.push_back(b);
            cs = cs ^ w[i];
        end
        b.data = cs;
        b.last = 1'b1;
        exp_q.push_back(b);
        m_seq = m_seq + 8'h01;
    endtask

    task automatic push_word(input logic [31:0] d);
        wb_valid = 1'b1;
        wb_data  = d;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL %s_drain_timeout: got %0d beats outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        wb_valid  = 1'b0;
        wb_data   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        m_seq = 8'h00;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (pkt_valid !== 1'b0 || pkt_last !== 1'b0 || pkt_data !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_stream: got valid=%b last=%b data=%h, expected 0 0 00000000",
                     pkt_valid, pkt_last, pkt_data);
        end
        n_checks++;
        if (fifo_level !== 4'd0) begin
            n_fails++;
            $display("FAIL reset_level: got %0d, expected 0", fifo_level);
        end
        n_checks++;
        if (overflow !== 1'b0 || drop_count !== 16'h0) begin
            n_fails++;
            $display("FAIL reset_drop: got overflow=%b drop_count=%0d, expected 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_basic();
        logic [31:0] w [C_N];
        pkt_ready = 1'b1;
        w = '{32'd1, 32'd2, 32'd3, 32'd4};
        expect_packet(w);
        for (int i = 0; i < C_N; i++) push_word(w[i]);
        n_checks++;
        if (fifo_level !== 4'd4 || pkt_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL basic_latency_k: got level=%0d valid=%b, expected 4 0", fifo_level, pkt_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== 32'hA5A5_0004) begin
            n_fails++;
            $display("FAIL basic_latency_k1: got valid=%b data=%h, expected 1 a5a50004", pkt_valid, pkt_data);
        end
        wait_drain("basic");
        n_checks++;
        if (pkt_valid !== 1'b0 || fifo_level !== 4'd0) begin
            n_fails++;
            $display("FAIL basic_idle_after: got valid=%b level=%0d, expected 0 0", pkt_valid, fifo_level);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w [C_N];
        int          s0;
        s0 = stall_seen;
        w = '{32'd1, 32'd2, 32'd3, 32'd4};
        expect_packet(w);
        fork
            begin
                for (int i = 0; i < C_N; i++) push_word(w[i]);
            end
            begin
                repeat (40) begin
                    pkt_ready = ~pkt_ready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        pkt_ready = 1'b1;
        wait_drain("stall");
        n_checks++;
        if (stall_seen <= s0) begin
            n_fails++;
            $display("FAIL stall_observed: got %0d stalled cycles, expected more than 0", stall_seen - s0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] w [C_N];
        pkt_ready = 1'b0;
        for (int i = 1; i <= 10; i++) push_word(32'(i));
        n_checks++;
        if (fifo_level !== 4'd8) begin
            n_fails++;
            $display("FAIL ovf_level: got %0d, expected 8", fifo_level);
        end
        n_checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd2) begin
            n_fails++;
            $display("FAIL ovf_drop: got overflow=%b drop_count=%0d, expected 1 2", overflow, drop_count);
        end
        w = '{32'd1, 32'd2, 32'd3, 32'd4};
        expect_packet(w);
        w = '{32'd5, 32'd6, 32'd7, 32'd8};
        expect_packet(w);
        pkt_ready = 1'b1;
        wait_drain("ovf");
        n_checks++;
        if (fifo_level !== 4'd0 || pkt_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            n_fails++;
            $display("FAIL ovf_after: got level=%0d valid=%b overflow=%b drops=%0d, expected 0 0 1 2",
                     fifo_level, pkt_valid, overflow, drop_count);
        end
    endtask

    task automatic test_full_payload();
        logic [31:0] w [C_N];
        apply_reset();
        pkt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < C_N; i++) w[i] = 32'h1001 + 32'(p * C_N + i);
            expect_packet(w);
        end
        for (int i = 0; i < 8; i++) push_word(32'h1001 + 32'(i));
        pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (fifo_level !== 4'd8) begin
            n_fails++;
            $display("FAIL full_before: got level=%0d, expected 8", fifo_level);
        end
        push_word(32'h1009);
        n_checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_fails++;
            $display("FAIL full_push_pop: got level=%0d overflow=%b drops=%0d, expected 8 0 0",
                     fifo_level, overflow, drop_count);
        end
        for (int i = 0; i < 3; i++) push_word(32'h100A + 32'(i));
        wait_drain("full");
    endtask

    task automatic test_seq_wrap();
        logic [31:0] w [C_N];
        int          h0;
        int          cyc;
        apply_reset();
        pkt_ready = 1'b1;
        h0 = hs_count;
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < C_N; i++) w[i] = 32'h0005_0000 + 32'(p * C_N + i);
            expect_packet(w);
            cyc = 0;
            while (fifo_level > 4'd4 && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            for (int i = 0; i < C_N; i++) push_word(w[i]);
        end
        wait_drain("seq");
        n_checks++;
        if (hs_count - h0 != 257 * (C_N + 2) || drop_count !== 16'd0) begin
            n_fails++;
            $display("FAIL seq_stream: got %0d beats drops=%0d, expected %0d beats 0 drops",
                     hs_count - h0, drop_count, 257 * (C_N + 2));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w [C_N];
        int          h0;
        int          cyc;
        pkt_ready = 1'b1;
        h0 = hs_count;
        w = '{32'hBEEF_0000, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003};
        expect_packet(w);
        for (int i = 0; i < C_N; i++) push_word(w[i]);
        cyc = 0;
        while (hs_count < h0 + 3 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (pkt_valid !== 1'b1 || pkt_data !== 32'hBEEF_0002) begin
            n_fails++;
            $display("FAIL mid_beat2: got valid=%b data=%h, expected 1 beef0002", pkt_valid, pkt_data);
        end
        #2;
        reset = 1'b0;
        exp_q.delete();
        m_seq = 8'h00;
        #1;
        n_checks++;
        if (pkt_valid !== 1'b0 || fifo_level !== 4'd0 || pkt_last !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_reset: got valid=%b level=%0d last=%b, expected 0 0 0",
                     pkt_valid, fifo_level, pkt_last);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        w = '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        expect_packet(w);
        for (int i = 0; i < C_N; i++) push_word(w[i]);
        wait_drain("mid");
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        hs_count   = 0;
        stall_seen = 0;
        m_seq      = 8'h00;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
        prev_last  = 1'b0;
        pkt_ready  = 1'b0;
        reset      = 1'b0;
        wb_valid   = 1'b0;
        wb_data    = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_full_payload();
        test_seq_wrap();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
